// File: rtl/mod_msg_schedule.sv
// SHA-2 message-schedule expander: latches a 16-word block, streams W[0..ROUNDS-1].
// Latency: W[0] valid the cycle after START; one word per cycle with w_ready held high.
// Backpressure: w_out/w_idx/buffer hold while w_valid & !w_ready; done pulses after last accept.
module mod_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [0:16*WORD_W-1]   block_in,
  input  logic                   w_ready,
  output logic [0:WORD_W-1]      w_out,
  output logic                   w_valid,
  output logic [6:0]             w_idx,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);
  localparam int S0_A = (WORD_W == 64) ? 1  : 7;
  localparam int S0_B = (WORD_W == 64) ? 8  : 18;
  localparam int S0_C = (WORD_W == 64) ? 7  : 3;
  localparam int S1_A = (WORD_W == 64) ? 19 : 17;
  localparam int S1_B = (WORD_W == 64) ? 61 : 19;
  localparam int S1_C = (WORD_W == 64) ? 6  : 10;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
  endfunction

  state_t            state_q, state_d;
  logic [6:0]        t_q;
  logic [WORD_W-1:0] wbuf [16];
  logic [WORD_W-1:0] w_q;
  logic              done_q;

  logic              load, hs, last_hs;
  logic [6:0]        t_nxt;
  logic [3:0]        n;
  logic [WORD_W-1:0] w_nxt;

  always_comb begin
    state_d = state_q;
    w_valid = 1'b0;
    busy    = 1'b0;
    load    = 1'b0;
    hs      = 1'b0;
    last_hs = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        hs      = w_ready;
        last_hs = w_ready && (t_q == T_LAST);
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Precompute W[t+1]; its operands never include W[t], so the buffer write-back
  // on this handshake cannot race with it.
  always_comb begin
    t_nxt = t_q + 7'd1;
    n     = t_nxt[3:0];
    if (t_nxt < 7'd16)
      w_nxt = wbuf[n];
    else
      w_nxt = sig1(wbuf[n - 4'd2]) + wbuf[n - 4'd7] + sig0(wbuf[n - 4'd15]) + wbuf[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q    <= 7'd0;
      w_q    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 16; i++) wbuf[i] <= '0;
    end else begin
      done_q <= last_hs;
      if (load) begin
        for (int i = 0; i < 16; i++) wbuf[i] <= block_in[i*WORD_W +: WORD_W];
        t_q <= 7'd0;
        w_q <= block_in[0 +: WORD_W];
      end else if (hs) begin
        if (t_q >= 7'd16) wbuf[t_q[3:0]] <= w_q;
        if (!last_hs) begin
          t_q <= t_nxt;
          w_q <= w_nxt;
        end
      end
    end
  end

  assign w_out = w_q;
  assign w_idx = t_q;
  assign done  = done_q;

endmodule
